safe_code_checker: RTL and testbench
====================================

// Module: safe_code_checker
// PURPOSE
//   Downstream consumer of the keypad scanner's 4-bit key stream. Collects digit
//   presses into a code buffer and compares the buffer with the stored combination
//   when ENTER is pressed. Drives the safe's unlock output and enforces a timed
//   lockout after repeated wrong codes.
// PARAMETERS
//   CODE_LEN        4          digits per combination, 1..8
//   DEFAULT_CODE    32'h1234   reset combination, BCD nibbles, low CODE_LEN nibbles used, last digit in [3:0]
//   MAX_FAILS       3          consecutive wrong ENTERs that trigger lockout, 1..15
//   LOCKOUT_CYCLES  24'd1000   lockout duration in clk cycles, >=1
//   UNLOCK_CYCLES   24'd500    unlock hold duration in clk cycles, >=1
// PORTS
//   clk          in   1            system clock
//   rst          in   1            synchronous, active-high reset
//   key_code     in   4            scanner output: 0-9 digit, 10 ENTER(hash), 11 STAR, 13 none; one-cycle pulse per press
//   unlocked     out  1            high while in UNLOCKED (and PROGRAM)
//   locked_out   out  1            high while in LOCKOUT
//   err_pulse    out  1            one-cycle pulse on each rejected ENTER
//   digit_count  out  4            digits currently held in buffer
//   fail_count   out  4            consecutive failures since last success or lockout
//   prog_active  out  1            high in PROGRAM; tied 0 without SAFE_REPROGRAM_EN
// BEHAVIOUR
//   Reset: state=IDLE, buffer=0, digit_count=0, overflow=0, fail_count=0, timer=0, code_reg=DEFAULT_CODE, all 1-bit outputs 0.
//   Key decode: 0-9 DIGIT, 10 ENTER, 11 STAR. Codes 12-15 are no-ops. Exactly one key is evaluated per cycle.
//   IDLE/ENTRY:
//     DIGIT: buffer <= {buffer, d} truncated to 4*CODE_LEN bits. digit_count++ (saturates at CODE_LEN).
//       A digit arriving at count==CODE_LEN sets overflow.
//     STAR: buffer, count and overflow cleared; next state IDLE. No fail is counted.
//     ENTER with count==0: ignored.
//     ENTER, match (count==CODE_LEN, !overflow, buffer==code_reg):
//       next state UNLOCKED, timer<=UNLOCK_CYCLES-1, fail_count<=0.
//     ENTER, mismatch: err_pulse=1 in the next cycle, fail_count++.
//       If the incremented value equals MAX_FAILS: LOCKOUT, timer<=LOCKOUT_CYCLES-1. Otherwise: IDLE.
//     Every ENTER clears buffer, count and overflow, pass or fail.
//   UNLOCKED: unlocked=1. Timer decrements each cycle; at 0 the next state is IDLE.
//     STAR relocks immediately (IDLE). DIGIT keys are ignored.
//     ENTER enters PROGRAM with the macro and is ignored without it.
//   LOCKOUT: locked_out=1. All keys ignored. Timer at 0: IDLE, fail_count<=0.
//   Outputs are registered. The state change lands the cycle after the key.
//   A key pulse coincident with timer==0: the timer expiry wins and the key is dropped.
//   Reset mid-operation aborts any state and restores code_reg to DEFAULT_CODE.
// CONFIGURATION
//   SAFE_REPROGRAM_EN defined: adds the PROGRAM state, reached by ENTER from UNLOCKED. Buffer is cleared on entry.
//     Digits shift in as in ENTRY.
//     ENTER with count==CODE_LEN and !overflow: code_reg<=buffer, return to UNLOCKED, timer reloaded.
//     ENTER otherwise: err_pulse, stay in PROGRAM, buffer cleared. STAR aborts to UNLOCKED with the timer reloaded.
//     The unlock timer is frozen while in PROGRAM.
//   SAFE_REPROGRAM_EN undefined: no PROGRAM state, code_reg is constant DEFAULT_CODE, prog_active=0.
// STRUCTURE
//   safe_pkg: KEY_ENTER=4'd10, KEY_STAR=4'd11, KEY_NONE=4'd13, state encodings IDLE/ENTRY/UNLOCKED/LOCKOUT/PROGRAM.
//     The scanner adopts the same key constants.
//   Sub-module safe_digit_buffer: shift register, saturating count, overflow flag, clear/compare ports.
//     It is shared by ENTRY and PROGRAM.
//   Top level holds the FSM, 24-bit down timer, fail counter and code_reg.
// TESTING
//   1 Correct code: keys 1,2,3,4,10 -> unlocked=1 one cycle after ENTER.
//     It stays high 500 cycles, then 0. fail_count=0.
//   2 Wrong code x3: (1,2,3,5,10) three times -> err_pulse three times.
//     fail_count 1,2, then locked_out=1. Keys 1,2,3,4,10 during lockout: no effect.
//     After 1000 cycles locked_out=0 and fail_count=0.
//   3 Overflow/short: 1,2,3,4,5,10 -> err_pulse, no unlock. 1,2,10 -> err_pulse.
//     10 with empty buffer -> no err_pulse, fail_count unchanged.
//   4 Star clear: 9,9,11,1,2,3,4,10 -> unlock. Star during UNLOCKED -> unlocked=0 next cycle.
//   5 Reset mid-entry: 1,2 then rst for 1 cycle -> digit_count=0, outputs 0, state IDLE.
//     Then 1,2,3,4,10 -> unlock.
//   6 SAFE_REPROGRAM_EN: unlock, 10, 5,6,7,8,10, then wait for relock.
//     1,2,3,4,10 -> err_pulse. 5,6,7,8,10 -> unlock. Without the macro, 5,6,7,8 is always rejected.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared key codes and FSM state encoding for the safe code checker.
// The keypad scanner uses the same key constants.
package safe_pkg;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_ENTER     = 4'd10;
  localparam logic [3:0] KEY_STAR      = 4'd11;
  localparam logic [3:0] KEY_NONE      = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_UNLOCKED,
    ST_LOCKOUT,
    ST_PROGRAM
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/safe_digit_buffer.sv
// Digit shift register with saturating count and overflow flag.
// Shared by code entry and reprogramming.
module safe_digit_buffer
  import safe_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [3:0]            digit_i,
  input  logic [4*CODE_LEN-1:0] ref_i,
  output logic [4*CODE_LEN-1:0] buf_o,
  output logic [3:0]            count_o,
  output logic                  valid_o,
  output logic                  match_o
);

  localparam int BW = 4 * CODE_LEN;
  localparam logic [3:0] FULL = 4'(CODE_LEN);

  logic [BW-1:0] buf_q, buf_d;
  logic [BW+3:0] shifted;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  assign shifted = {buf_q, digit_i};

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_i) begin
      buf_d = shifted[BW-1:0];
      if (cnt_q == FULL) ovf_d = 1'b1;
      else cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign buf_o   = buf_q;
  assign count_o = cnt_q;
  assign valid_o = (cnt_q == FULL) && !ovf_q;
  assign match_o = valid_o && (buf_q == ref_i);

endmodule

// File: rtl/safe_code_checker.sv
// Safe combination checker: entry FSM, unlock/lockout timer, fail counter.
// Define SAFE_REPROGRAM_EN to add the PROGRAM state for changing the code.
module safe_code_checker
  import safe_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [31:0] DEFAULT_CODE   = 32'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd1000,
  parameter logic [23:0] UNLOCK_CYCLES  = 24'd500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       locked_out,
  output logic       err_pulse,
  output logic [3:0] digit_count,
  output logic [3:0] fail_count,
  output logic       prog_active
);

  localparam int          BW     = 4 * CODE_LEN;
  localparam logic [23:0] U_LOAD = UNLOCK_CYCLES - 24'd1;
  localparam logic [23:0] L_LOAD = LOCKOUT_CYCLES - 24'd1;
  localparam logic [3:0]  FMAX   = 4'(MAX_FAILS);

  state_e        state_q, state_d;
  logic [23:0]   timer_q, timer_d;
  logic [3:0]    fail_q, fail_d, fail_inc;
  logic          err_q, err_d;
  logic          clr, shift, valid, match;
  logic [BW-1:0] code, buf_val;
  logic          k_dig, k_ent, k_star;

  assign k_dig  = is_digit(key_code);
  assign k_ent  = key_code == KEY_ENTER;
  assign k_star = key_code == KEY_STAR;
  assign fail_inc = fail_q + 4'd1;

  safe_digit_buffer #(.CODE_LEN(CODE_LEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .shift_i (shift),
    .digit_i (key_code),
    .ref_i   (code),
    .buf_o   (buf_val),
    .count_o (digit_count),
    .valid_o (valid),
    .match_o (match)
  );

`ifdef SAFE_REPROGRAM_EN
  logic [BW-1:0] code_q, code_d;
  assign code = code_q;
  always_ff @(posedge clk) begin
    if (rst) code_q <= DEFAULT_CODE[BW-1:0];
    else     code_q <= code_d;
  end
`else
  logic unused_buf;
  assign code = DEFAULT_CODE[BW-1:0];
  assign unused_buf = ^buf_val;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
`ifdef SAFE_REPROGRAM_EN
    code_d  = code_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (k_dig) begin
          shift   = 1'b1;
          state_d = ST_ENTRY;
        end else if (k_star) begin
          clr     = 1'b1;
          state_d = ST_IDLE;
        end else if (k_ent && digit_count != 4'd0) begin
          clr = 1'b1;
          if (match) begin
            state_d = ST_UNLOCKED;
            timer_d = U_LOAD;
            fail_d  = '0;
          end else begin
            err_d   = 1'b1;
            fail_d  = fail_inc;
            state_d = ST_IDLE;
            if (fail_inc == FMAX) begin
              state_d = ST_LOCKOUT;
              timer_d = L_LOAD;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        // Expiry takes priority over any key in the same cycle
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 24'd1;
          if (k_star) state_d = ST_IDLE;
`ifdef SAFE_REPROGRAM_EN
          else if (k_ent) begin
            state_d = ST_PROGRAM;
            clr     = 1'b1;
          end
`endif
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 24'd1;
        end
      end
`ifdef SAFE_REPROGRAM_EN
      ST_PROGRAM: begin
        if (k_dig) begin
          shift = 1'b1;
        end else if (k_star) begin
          clr     = 1'b1;
          state_d = ST_UNLOCKED;
          timer_d = U_LOAD;
        end else if (k_ent) begin
          clr = 1'b1;
          if (valid) begin
            code_d  = buf_val;
            state_d = ST_UNLOCKED;
            timer_d = U_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign unlocked   = (state_q == ST_UNLOCKED) || (state_q == ST_PROGRAM);
  assign locked_out = state_q == ST_LOCKOUT;
  assign err_pulse  = err_q;
  assign fail_count = fail_q;
`ifdef SAFE_REPROGRAM_EN
  assign prog_active = state_q == ST_PROGRAM;
`else
  assign prog_active = 1'b0;
`endif

endmodule

// File: tb/tb_safe_code_checker.sv
// Randomized scoreboard bench for safe_code_checker against a
// digit-queue reference model of the safe.
module tb_safe_code_checker;

  localparam int LEN   = 4;
  localparam int DEF   = 32'h1234;
  localparam int MAXF  = 3;
  localparam int LOCKC = 1000;
  localparam int UNLC  = 500;
`ifdef SAFE_REPROGRAM_EN
  localparam bit REPROG = 1'b1;
`else
  localparam bit REPROG = 1'b0;
`endif

  typedef struct packed {
    logic       u;
    logic       l;
    logic       e;
    logic [3:0] cnt;
    logic [3:0] fc;
    logic       p;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'd13;
  logic       unlocked, locked_out, err_pulse, prog_active;
  logic [3:0] digit_count, fail_count;

  always #5 clk = ~clk;

  safe_code_checker dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .err_pulse   (err_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count),
    .prog_active (prog_active)
  );

  // Reference model: modes of the safe, digits as a plain queue
  localparam int M_CLOSED = 0, M_OPEN = 1, M_BLOCK = 2, M_PROG = 3;
  int   mode, fails, remain;
  int   digs[$];
  int   code_m[LEN];
  bit   err_m;
  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic bool_match();
    if (digs.size() != LEN) return 0;
    for (int i = 0; i < LEN; i++)
      if (digs[i] != code_m[i]) return 0;
    return 1;
  endfunction

  function automatic void model_reset();
    mode = M_CLOSED; fails = 0; remain = 0; err_m = 0;
    digs.delete();
    for (int i = 0; i < LEN; i++)
      code_m[i] = (DEF >> (4 * (LEN - 1 - i))) & 15;
  endfunction

  function automatic void add_digit(int k);
    if (digs.size() <= LEN) digs.push_back(k);
  endfunction

  function automatic void model_step(int k);
    err_m = 0;
    case (mode)
      M_CLOSED: begin
        if (k <= 9) add_digit(k);
        else if (k == 11) digs.delete();
        else if (k == 10 && digs.size() > 0) begin
          if (bool_match()) begin
            mode = M_OPEN; remain = UNLC - 1; fails = 0;
          end else begin
            err_m = 1; fails++;
            if (fails == MAXF) begin
              mode = M_BLOCK; remain = LOCKC - 1;
            end
          end
          digs.delete();
        end
      end
      M_OPEN: begin
        if (remain == 0) mode = M_CLOSED;
        else begin
          remain--;
          if (k == 11) mode = M_CLOSED;
          else if (k == 10 && REPROG) begin
            mode = M_PROG; digs.delete();
          end
        end
      end
      M_BLOCK: begin
        if (remain == 0) begin
          mode = M_CLOSED; fails = 0;
        end else remain--;
      end
      default: begin
        if (k <= 9) add_digit(k);
        else if (k == 11) begin
          digs.delete(); mode = M_OPEN; remain = UNLC - 1;
        end else if (k == 10) begin
          if (digs.size() == LEN) begin
            for (int i = 0; i < LEN; i++) code_m[i] = digs[i];
            mode = M_OPEN; remain = UNLC - 1;
          end else err_m = 1;
          digs.delete();
        end
      end
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.u   = (mode == M_OPEN) || (mode == M_PROG);
    o.l   = mode == M_BLOCK;
    o.e   = err_m;
    o.cnt = 4'((digs.size() > LEN) ? LEN : digs.size());
    o.fc  = 4'(fails);
    o.p   = mode == M_PROG;
    return o;
  endfunction

  task automatic drive(input int k);
    @(negedge clk);
    rst = 1'b0;
    key_code = 4'(k);
    model_step(k);
    expq.push_back(model_obs());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_code = 4'd13;
    model_reset();
    expq.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(13);
  endtask

  task automatic seq5(input int a, input int b, input int c,
                      input int d, input int e);
    drive(a); drive(b); drive(c); drive(d); drive(e);
  endtask

  task automatic send_code();
    int c[LEN];
    c = code_m;
    for (int i = 0; i < LEN; i++) drive(c[i]);
    drive(10);
  endtask

  // Monitor: one observation per clock, compared after the active edge
  initial begin
    obs_t got, exp_o;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_o = expq.pop_front();
        got = '{unlocked, locked_out, err_pulse, digit_count,
                fail_count, prog_active};
        checks++;
        if (got !== exp_o) begin
          errors++;
          $display("FAIL outputs t=%0t got u=%b l=%b e=%b cnt=%0d fc=%0d p=%b exp u=%b l=%b e=%b cnt=%0d fc=%0d p=%b",
                   $time, got.u, got.l, got.e, got.cnt, got.fc, got.p,
                   exp_o.u, exp_o.l, exp_o.e, exp_o.cnt, exp_o.fc, exp_o.p);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    do_reset();
    idle(3);
    seq5(1, 2, 3, 4, 10);
    idle(505);
    for (int i = 0; i < 3; i++) seq5(1, 2, 3, 5, 10);
    seq5(1, 2, 3, 4, 10);
    idle(1000);
    drive(1); seq5(2, 3, 4, 5, 10);
    drive(1); drive(2); drive(10);
    drive(10);
    idle(2);
    drive(9); drive(9); drive(11);
    seq5(1, 2, 3, 4, 10);
    idle(5); drive(11); idle(3);
    drive(1); drive(2);
    do_reset();
    seq5(1, 2, 3, 4, 10);
    idle(499); drive(11); drive(10); idle(2);
    seq5(1, 2, 3, 4, 10);
    drive(10);
    seq5(5, 6, 7, 8, 10);
    idle(505);
    seq5(1, 2, 3, 4, 10);
    idle(2);
    seq5(5, 6, 7, 8, 10);
    idle(3); drive(11); idle(3);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) send_code();
      else if (r < 9) do_reset();
      else if (r < 11) idle($urandom_range(100, 600));
      else drive($urandom_range(0, 15));
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
